pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequencer for the 5-stage pipeline's hold/flush controls; replaces the combinational hold mux.
//  Detects load-use hazards between ID and EX and inserts bubbles.
//  Sequences multi-cycle flushes after a taken jump, and freezes the pipe for div/clint/JTAG holds.
//  Drives pc_reg, if_id and id_ex; counts stall cycles for perf debug.
// PARAMETERS
//  FLUSH_CYCLES  2  cycles flush_o=2'b11 after an accepted jump (>=1)
//  LOAD_STALL    1  bubble cycles per load-use hit (>=1)
// PORTS
//  clk            in   1   clock
//  rst            in   1   async reset, active-low
//  jump_req_i     in   1   taken jump/branch from EX
//  jump_addr_i    in   32  jump target
//  ex_load_i      in   1   instruction in EX is a load
//  ex_rd_i        in   5   EX destination register
//  id_rs1_i       in   5   ID source reg 1
//  id_rs2_i       in   5   ID source reg 2
//  id_rs1_use_i   in   1   ID instruction reads rs1
//  id_rs2_use_i   in   1   ID instruction reads rs2
//  hold_ex_i      in   1   EX multi-cycle hold (divider busy)
//  hold_clint_i   in   1   interrupt controller hold
//  hold_rib_i     in   1   bus arbitration hold (fetch port lost)
//  jtag_halt_i    in   1   debug halt request
//  hold_flag_o    out  3   0 none, 1 PC held, 2 PC+IF/ID held, 3 PC+IF/ID+ID/EX held
//  flush_o        out  2   [0] kill IF/ID, [1] bubble into ID/EX
//  jump_flag_o    out  1   jump to pc_reg
//  jump_addr_o    out  32  jump target to pc_reg
//  state_o        out  2   FSM state: 0 RUN, 1 LDSTALL, 2 FLUSH, 3 HALT
//  stall_cycles_o out  32  count of cycles with hold_flag_o!=0, saturating
// BEHAVIOUR
//  Reset (rst=0, async): state RUN, counter cnt=0, stall_cycles_o=0.
//   While rst=0, all outputs are 0.
//  Load-use hit (lu):
//   ex_load_i & ex_rd_i!=0 & ((id_rs1_use_i & id_rs1_i==ex_rd_i) | (id_rs2_use_i & id_rs2_i==ex_rd_i)).
//  jump_flag_o/jump_addr_o: combinational pass-through of jump_req_i/jump_addr_i when state!=HALT.
//   In HALT both are 0.
//  Next-state priority, evaluated each cycle: jtag_halt_i > jump_req_i > hold_ex_i|hold_clint_i (freeze) > lu.
//  RUN:
//   jtag_halt_i -> HALT.
//   jump_req_i -> flush_o=11 this cycle; FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else stay RUN.
//   freeze -> hold_flag_o=3, stay RUN.
//   lu -> hold_flag_o=2 and flush_o=10 this cycle; LDSTALL with cnt=LOAD_STALL-1 if LOAD_STALL>1, else stay RUN.
//  LDSTALL: hold_flag_o=2, flush_o=10; cnt decrements; cnt==1 -> RUN next.
//   Jump or halt preempts per priority.
//   Freeze: hold_flag_o=3, flush_o=00, cnt unchanged.
//  FLUSH: flush_o=11, hold_flag_o=0; cnt decrements; cnt==1 -> RUN.
//   New jump_req_i reloads cnt=FLUSH_CYCLES-1 (restart).
//   Freeze during FLUSH: flush_o=11 continues, cnt unchanged.
//   lu ignored (ID is being killed).
//  HALT: hold_flag_o=3, flush_o=00, jump ignored, lu ignored.
//   jtag_halt_i=0 -> RUN next cycle; cnt cleared.
//  hold_rib_i: raises hold_flag_o to at least 1 in any state (final hold = max of all sources).
//   Does not change state or cnt.
//  stall_cycles_o: +1 on every clock edge with hold_flag_o!=0; holds at 32'hFFFF_FFFF.
//  hold_flag_o/flush_o are Mealy: valid in the same cycle as the triggering input.
// TESTING
//  1. LOAD_STALL=1: lw x5 in EX, add x6,x5,x1 in ID -> one cycle hold=2, flush=10; next cycle hold=0, state RUN.
//  2. lu with ex_rd_i=0 (lw x0), or id_rs1_use_i=0 -> no stall, hold=0.
//  3. FLUSH_CYCLES=2: jump_req_i=1, addr=0x100 -> jump_flag_o=1, addr 0x100, flush=11 for 2 cycles, then RUN.
//     Second jump in cycle 2 -> 2 further flush cycles.
//  4. hold_ex_i=1 for 5 cycles during LDSTALL (LOAD_STALL=3) -> hold=3 for 5 cycles, cnt frozen.
//     Then 2 remaining LDSTALL cycles.
//  5. jtag_halt_i with jump_req_i in the same cycle -> HALT, jump_flag_o=0 from next cycle, hold=3.
//     Release -> RUN.
//  6. rst low mid-FLUSH -> outputs 0 immediately, state 0, stall_cycles_o=0.
//     Separately: preload stall counter near 2^32 -> saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_hazard_ctrl: hold/flush sequencer for the 5-stage pipeline           |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
    parameter int          FLUSH_CYCLES  = 2,
    parameter int          LOAD_STALL    = 1,
    parameter logic [31:0] STALL_PRELOAD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ex_load_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_rs1_use_i,
    input  logic        id_rs2_use_i,
    input  logic        hold_ex_i,
    input  logic        hold_clint_i,
    input  logic        hold_rib_i,
    input  logic        jtag_halt_i,
    output logic [2:0]  hold_flag_o,
    output logic [1:0]  flush_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cycles_o
);

    localparam int C_MAXC  = (FLUSH_CYCLES > LOAD_STALL) ? FLUSH_CYCLES : LOAD_STALL;
    localparam int C_CNT_W = $clog2(C_MAXC + 1);
    localparam logic [C_CNT_W-1:0] C_FLUSH_RELOAD = C_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_LOAD_RELOAD  = C_CNT_W'(LOAD_STALL - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LDSTALL = 2'd1,
        S_FLUSH   = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]          r_stall;
    logic [2:0]           w_hold_fsm;
    logic [2:0]           w_hold;
    logic [1:0]           w_flush;
    logic                 w_lu;
    logic                 w_freeze;

    assign w_lu = ex_load_i && (ex_rd_i != 5'd0) &&
                  ((id_rs1_use_i && (id_rs1_i == ex_rd_i)) ||
                   (id_rs2_use_i && (id_rs2_i == ex_rd_i)));
    assign w_freeze = hold_ex_i | hold_clint_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hold_fsm  = 3'd0;
        w_flush     = 2'b00;
        case (r_state)
            S_RUN, S_LDSTALL: begin
                if (jtag_halt_i) begin
                    w_state_nxt = S_HALT;
                end else if (jump_req_i) begin
                    w_flush     = 2'b11;
                    w_state_nxt = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
                    w_cnt_nxt   = (FLUSH_CYCLES > 1) ? C_FLUSH_RELOAD : '0;
                end else if (w_freeze) begin
                    w_hold_fsm = 3'd3;
                end else if (r_state == S_LDSTALL) begin
                    w_hold_fsm = 3'd2;
                    w_flush    = 2'b10;
                    if (r_cnt <= C_CNT_W'(1)) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - C_CNT_W'(1);
                    end
                end else if (w_lu) begin
                    w_hold_fsm  = 3'd2;
                    w_flush     = 2'b10;
                    w_state_nxt = (LOAD_STALL > 1) ? S_LDSTALL : S_RUN;
                    w_cnt_nxt   = (LOAD_STALL > 1) ? C_LOAD_RELOAD : '0;
                end
            end
            S_FLUSH: begin
                // ID is being killed here, so a load-use match is meaningless
                if (jtag_halt_i) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_flush = 2'b11;
                    if (jump_req_i) begin
                        w_cnt_nxt = C_FLUSH_RELOAD;
                    end else if (w_freeze) begin
                        w_hold_fsm = 3'd3;
                    end else if (r_cnt <= C_CNT_W'(1)) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - C_CNT_W'(1);
                    end
                end
            end
            S_HALT: begin
                w_hold_fsm = 3'd3;
                if (!jtag_halt_i) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_hold = (hold_rib_i && (w_hold_fsm == 3'd0)) ? 3'd1 : w_hold_fsm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= STALL_PRELOAD;
        end else if ((w_hold != 3'd0) && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign hold_flag_o    = rst ? w_hold : 3'd0;
    assign flush_o        = rst ? w_flush : 2'b00;
    assign jump_flag_o    = rst && (r_state != S_HALT) && jump_req_i;
    assign jump_addr_o    = (rst && (r_state != S_HALT)) ? jump_addr_i : 32'h0;
    assign state_o        = r_state;
    assign stall_cycles_o = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl: two configurations against a cycle reference model   |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

    localparam int          F0   = 2;
    localparam int          L0   = 1;
    localparam int          F1   = 2;
    localparam int          L1   = 3;
    localparam logic [31:0] PRE1 = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_req;
    logic [31:0] jump_addr;
    logic        ex_load;
    logic [4:0]  ex_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_use;
    logic        rs2_use;
    logic        hold_ex;
    logic        hold_clint;
    logic        hold_rib;
    logic        halt;

    logic [2:0]  hold_o  [2];
    logic [1:0]  flush_o [2];
    logic        jf_o    [2];
    logic [31:0] ja_o    [2];
    logic [1:0]  st_o    [2];
    logic [31:0] stall_o [2];

    int checks   = 0;
    int failures = 0;

    int     m_halted [2];
    int     m_fl     [2];
    int     m_ld     [2];
    longint m_stall  [2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(F0), .LOAD_STALL(L0), .STALL_PRELOAD(32'h0)) dut0 (
        .clk(clk), .rst(rst), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
        .ex_load_i(ex_load), .ex_rd_i(ex_rd), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_rs1_use_i(rs1_use), .id_rs2_use_i(rs2_use), .hold_ex_i(hold_ex),
        .hold_clint_i(hold_clint), .hold_rib_i(hold_rib), .jtag_halt_i(halt),
        .hold_flag_o(hold_o[0]), .flush_o(flush_o[0]), .jump_flag_o(jf_o[0]),
        .jump_addr_o(ja_o[0]), .state_o(st_o[0]), .stall_cycles_o(stall_o[0])
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(F1), .LOAD_STALL(L1), .STALL_PRELOAD(PRE1)) dut1 (
        .clk(clk), .rst(rst), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
        .ex_load_i(ex_load), .ex_rd_i(ex_rd), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_rs1_use_i(rs1_use), .id_rs2_use_i(rs2_use), .hold_ex_i(hold_ex),
        .hold_clint_i(hold_clint), .hold_rib_i(hold_rib), .jtag_halt_i(halt),
        .hold_flag_o(hold_o[1]), .flush_o(flush_o[1]), .jump_flag_o(jf_o[1]),
        .jump_addr_o(ja_o[1]), .state_o(st_o[1]), .stall_cycles_o(stall_o[1])
    );

    task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, exp);
        end
    endtask

    task automatic clear_in();
        jump_req = 1'b0; jump_addr = 32'h0; ex_load = 1'b0; ex_rd = 5'd0;
        rs1 = 5'd0; rs2 = 5'd0; rs1_use = 1'b0; rs2_use = 1'b0;
        hold_ex = 1'b0; hold_clint = 1'b0; hold_rib = 1'b0; halt = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_halted[i] = 0;
            m_fl[i]     = 0;
            m_ld[i]     = 0;
            m_stall[i]  = (i == 0) ? 64'd0 : longint'(PRE1);
        end
    endtask

    // One checked clock: compare at negedge+1, then let the posedge happen
    task automatic cyc();
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            int          f;
            int          l;
            logic [2:0]  eh;
            logic [1:0]  ef;
            logic [1:0]  es;
            logic        ej;
            logic [31:0] ea;
            logic        lu;
            f  = (i == 0) ? F0 : F1;
            l  = (i == 0) ? L0 : L1;
            lu = ex_load && (ex_rd != 5'd0) &&
                 ((rs1_use && (rs1 == ex_rd)) || (rs2_use && (rs2 == ex_rd)));
            eh = 3'd0; ef = 2'd0; ej = 1'b0; ea = 32'h0;
            es = (m_halted[i] != 0) ? 2'd3 : (m_fl[i] > 0) ? 2'd2 : (m_ld[i] > 0) ? 2'd1 : 2'd0;
            if (m_halted[i] != 0) begin
                eh = 3'd3;
                if (!halt) m_halted[i] = 0;
            end else begin
                ej = jump_req;
                ea = jump_addr;
                if (halt) begin
                    m_halted[i] = 1; m_fl[i] = 0; m_ld[i] = 0;
                end else if (jump_req) begin
                    ef = 2'b11; m_fl[i] = f - 1; m_ld[i] = 0;
                end else if (hold_ex || hold_clint) begin
                    eh = 3'd3; ef = (m_fl[i] > 0) ? 2'b11 : 2'b00;
                end else if (m_fl[i] > 0) begin
                    ef = 2'b11; m_fl[i]--;
                end else if (m_ld[i] > 0) begin
                    eh = 3'd2; ef = 2'b10; m_ld[i]--;
                end else if (lu) begin
                    eh = 3'd2; ef = 2'b10; m_ld[i] = l - 1;
                end
            end
            if (hold_rib && (eh == 3'd0)) eh = 3'd1;
            chk("hold",  i, 32'(hold_o[i]),  32'(eh));
            chk("flush", i, 32'(flush_o[i]), 32'(ef));
            chk("jflag", i, 32'(jf_o[i]),    32'(ej));
            chk("jaddr", i, ja_o[i],         ea);
            chk("state", i, 32'(st_o[i]),    32'(es));
            chk("stall", i, stall_o[i],      32'(m_stall[i]));
            if ((eh != 3'd0) && (m_stall[i] < 64'hFFFF_FFFF)) m_stall[i]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_hold",  i, 32'(hold_o[i]),  32'd0);
            chk("rst_flush", i, 32'(flush_o[i]), 32'd0);
            chk("rst_jflag", i, 32'(jf_o[i]),    32'd0);
            chk("rst_jaddr", i, ja_o[i],         32'd0);
            chk("rst_state", i, 32'(st_o[i]),    32'd0);
            chk("rst_stall", i, stall_o[i],      32'(m_stall[i]));
        end
        clear_in();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] a, input logic ua,
                          input logic [4:0] b, input logic ub);
        ex_load = 1'b1; ex_rd = rd; rs1 = a; rs1_use = ua; rs2 = b; rs2_use = ub;
    endtask

    initial begin
        clear_in();
        model_reset();
        do_reset();

        // load-use on rs1, then let the 3-cycle instance drain
        set_lu(5'd5, 5'd5, 1'b1, 5'd1, 1'b1); cyc();
        clear_in(); repeat (3) cyc();

        // no-stall cases: x0 destination, unused rs1; then hit through rs2
        set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); cyc();
        set_lu(5'd5, 5'd5, 1'b0, 5'd6, 1'b1); cyc();
        set_lu(5'd7, 5'd1, 1'b1, 5'd7, 1'b1); cyc();
        clear_in(); repeat (3) cyc();

        // jump, then jump restart inside the flush window
        jump_req = 1'b1; jump_addr = 32'h0000_0100; cyc();
        clear_in(); repeat (2) cyc();
        jump_req = 1'b1; jump_addr = 32'h0000_0200; cyc();
        jump_req = 1'b1; jump_addr = 32'h0000_0300; cyc();
        clear_in(); repeat (3) cyc();

        // divider freeze in the middle of a long load stall
        set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); cyc();
        clear_in(); hold_ex = 1'b1; repeat (5) cyc();
        hold_ex = 1'b0; repeat (3) cyc();

        // halt wins over a simultaneous jump; jump stays asserted while halted
        halt = 1'b1; jump_req = 1'b1; jump_addr = 32'hDEAD_BEEC; repeat (4) cyc();
        halt = 1'b0; cyc();
        clear_in(); cyc();

        // reset in the middle of a flush
        jump_req = 1'b1; jump_addr = 32'h0000_0400; cyc();
        clear_in();
        do_reset();
        cyc();

        // bus hold alone, then long interrupt freeze to saturate the preloaded counter
        hold_rib = 1'b1; repeat (2) cyc();
        clear_in(); hold_clint = 1'b1; repeat (20) cyc();
        clear_in(); cyc();

        // constrained random traffic
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            halt       = ($urandom_range(0, 15) == 0);
            jump_req   = ($urandom_range(0, 7) == 0);
            jump_addr  = $urandom;
            hold_ex    = ($urandom_range(0, 7) == 0);
            hold_clint = ($urandom_range(0, 15) == 0);
            hold_rib   = ($urandom_range(0, 7) == 0);
            ex_load    = ($urandom_range(0, 1) == 1);
            ex_rd      = 5'($urandom_range(0, 3));
            rs1        = 5'($urandom_range(0, 3));
            rs2        = 5'($urandom_range(0, 3));
            rs1_use    = ($urandom_range(0, 1) == 1);
            rs2_use    = ($urandom_range(0, 1) == 1);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
